inst_window_fetch: RTL and testbench
====================================

Name: inst_window_fetch

Overview:
- Parametrised instruction-window fetch unit between the cpu fetch port and a set of interleaved single-cycle-latency ROM banks.
- Returns WINDOW consecutive instructions for any base address in one access, using BANKS narrow banks instead of one full-size ROM copy per lane.
- Adds a valid/ready request and response handshake, a small output buffer, flush on redirect, and address wrap-around.

Parameters:
- INSTR_WIDTH, 16, instruction width in bits.
- ADDR_WIDTH, 10, word address width; address space is 2**ADDR_WIDTH words.
- WINDOW, 20, instructions per response; must be <= BANKS.
- BANKS, 32, bank count; power of two; LB = $clog2(BANKS); each bank has 2**(ADDR_WIDTH-LB) rows.
- OUT_DEPTH, 2, output buffer entries; must be >= 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  request accepted when req_valid && req_ready (fire).
- req_addr  in  ADDR_WIDTH  window base word address.
- flush  in  1  redirect; discards in-flight and buffered responses.
- bank_addr  out  BANKS*(ADDR_WIDTH-LB)  row address per bank; bank k occupies slice k.
- bank_q  in  BANKS*INSTR_WIDTH  bank read data, valid one cycle after bank_addr is presented.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready (pop).
- rsp_addr  out  ADDR_WIDTH  base address of the head response.
- rsp_window  out  WINDOW*INSTR_WIDTH  lane i = word at (rsp_addr+i) mod 2**ADDR_WIDTH; lane 0 in the LSBs.

Behaviour:
- Bank mapping: word w lives in bank w[LB-1:0], row w>>LB.
- Bank row selection for base b (b_lo = b[LB-1:0], b_hi = b>>LB): bank k reads row (b_hi + (k < b_lo)) mod 2**(ADDR_WIDTH-LB). The row wraps at the top of the address space, so 0x3FF+1 reaches word 0.
- bank_addr timing: computed combinationally from req_addr in a fire cycle; otherwise computed from last_addr, a register holding the last accepted address.
- Lane rotation: lane i = bank (b_lo+i) mod BANKS, using the b_lo captured with the request.
- Pipeline: request fires in cycle T; bank_q is valid in T+1 and the rotated window is written into the buffer at the end of T+1; rsp_valid is high in T+2. Latency is 2 cycles.
- Throughput: 1 window per cycle while rsp_ready is held high.
- Counters: inflight (0/1) and occ (0..OUT_DEPTH).
- req_ready = flush || (occ + inflight - pop) < OUT_DEPTH. The combinational path from rsp_ready to req_ready is intended.
- Buffer: in-order FIFO; rsp_valid = (occ != 0); rsp_addr and rsp_window are driven from the head entry.
- Head stability: while rsp_valid && !rsp_ready, the head outputs stay stable.
- Simultaneous push and pop with occ=OUT_DEPTH cannot happen, because req_ready prevents it.
- Flush: a pop in the flush cycle is legal. At the edge, occ and inflight clear and stale bank_q data arriving in the next cycle is discarded. A request firing in the flush cycle is retained and responds at T+2. rsp_valid is low in the cycle after a flush unless buffer data arrives.
- Reset (resetN=0): occ=0, inflight=0, last_addr=0, rsp_valid=0, rsp_addr=0, rsp_window=0, optional counter=0. req_ready=1 in the first cycle after release.
- Reset asserted mid-operation drops all state immediately; nothing from before reset may appear on rsp_*.

Optional Feature:
- Macro: INST_WIN_STALL_CNT_EN.
- Defined: adds output port stall_cnt (out, 16 bits), which increments each cycle where req_valid && !req_ready. It saturates at 0xFFFF, clears on reset, and is not affected by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Banks preloaded so word w = 16'hA000|w; request addr 0x000 with rsp_ready=1 -> rsp_valid at T+2, lanes 0..19 = 0xA000..0xA013, rsp_addr=0x000.
- Unaligned request 0x01E (b_lo=30) -> lanes 0..19 = 0xA01E..0xA031; banks 0..17 are read at row 1.
- Wrap request 0x3F5 -> lanes 0..10 = 0xA3F5..0xA3FF, lanes 11..19 = 0xA000..0xA008.
- Backpressure: 5 back-to-back requests 0x000,0x014,0x028,0x03C,0x050 with rsp_ready=0 for 6 cycles -> req_ready drops after 2 accepts. On release, responses arrive in order with no loss or duplication. With INST_WIN_STALL_CNT_EN, stall_cnt equals the stall cycles counted.
- Flush: request 0x100 fires, next cycle flush=1 with req 0x200 -> no response for 0x100; the 0x200 response arrives 2 cycles after its fire.
- Reset mid-stream: resetN low for 1 cycle with occ=2 -> rsp_valid=0 immediately; the next request 0x040 responds with 0xA040.. at T+2.

Source files
------------

// File: rtl/inst_window_fetch.sv
// inst_window_fetch: fetches WINDOW consecutive instructions from BANKS interleaved ROM banks per request.
// Optional stall_cnt output is enabled by defining INST_WIN_STALL_CNT_EN.
module inst_window_fetch #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int WINDOW      = 20,
  parameter int BANKS       = 32,
  parameter int OUT_DEPTH   = 2
) (
  input  logic                                         clk,
  input  logic                                         resetN,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic [ADDR_WIDTH-1:0]                        req_addr,
  input  logic                                         flush,
  output logic [BANKS*(ADDR_WIDTH-$clog2(BANKS))-1:0]  bank_addr,
  input  logic [BANKS*INSTR_WIDTH-1:0]                 bank_q,
  output logic                                         rsp_valid,
  input  logic                                         rsp_ready,
  output logic [ADDR_WIDTH-1:0]                        rsp_addr,
  output logic [WINDOW*INSTR_WIDTH-1:0]                rsp_window
`ifdef INST_WIN_STALL_CNT_EN
  ,
  output logic [15:0]                                  stall_cnt
`endif
);
  localparam int LB = $clog2(BANKS);
  localparam int RW = ADDR_WIDTH - LB;
  localparam int IW = INSTR_WIDTH;
  localparam int WW = WINDOW * IW;
  localparam int PW = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1) + 1;
  logic [ADDR_WIDTH-1:0] last_addr, base;
  logic                  inflight, fire, pop, push;
  logic [CW-1:0]         occ;
  logic [PW-1:0]         wr, rd;
  logic [ADDR_WIDTH-1:0] mem_addr [OUT_DEPTH];
  logic [WW-1:0]         mem_win  [OUT_DEPTH];
  logic [WW-1:0]         rot;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(OUT_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign rsp_valid  = occ != '0;
  assign pop        = rsp_valid && rsp_ready;
  assign req_ready  = flush || (occ + CW'(inflight) - CW'(pop)) < CW'(OUT_DEPTH);
  assign fire       = req_valid && req_ready;
  assign push       = inflight && !flush;
  assign base       = fire ? req_addr : last_addr;
  assign rsp_addr   = mem_addr[rd];
  assign rsp_window = mem_win[rd];
  // banks below the base offset belong to the next row of the window
  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    assign bank_addr[k*RW +: RW] = base[ADDR_WIDTH-1:LB] + RW'(LB'(k) < base[LB-1:0]);
  end
  for (genvar i = 0; i < WINDOW; i++) begin : g_lane
    logic [LB-1:0] sel;
    assign sel = last_addr[LB-1:0] + LB'(i);
    assign rot[i*IW +: IW] = bank_q[sel*IW +: IW];
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_addr <= '0;
      inflight  <= 1'b0;
      occ       <= '0;
      wr        <= '0;
      rd        <= '0;
      for (int j = 0; j < OUT_DEPTH; j++) begin
        mem_addr[j] <= '0;
        mem_win[j]  <= '0;
      end
    end else begin
      if (fire) last_addr <= req_addr;
      inflight <= fire;
      if (flush) begin
        occ <= '0;
        wr  <= '0;
        rd  <= '0;
      end else begin
        occ <= occ + CW'(push) - CW'(pop);
        if (push) begin
          mem_addr[wr] <= last_addr;
          mem_win[wr]  <= rot;
          wr           <= nxt(wr);
        end
        if (pop) rd <= nxt(rd);
      end
    end
  end
`ifdef INST_WIN_STALL_CNT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) stall_cnt <= '0;
    else if (req_valid && !req_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_inst_window_fetch.sv
// tb_inst_window_fetch: directed bench for inst_window_fetch with a word-addressed ROM model (word w = 0xA000|w).
module tb_inst_window_fetch;
  localparam int AW = 10, IW = 16, W = 20, B = 32, RW = 5;
  logic              clk, resetN, req_valid, req_ready, flush, rsp_valid, rsp_ready;
  logic [AW-1:0]     req_addr, rsp_addr;
  logic [B*RW-1:0]   bank_addr;
  logic [B*IW-1:0]   bank_q;
  logic [W*IW-1:0]   rsp_window;
`ifdef INST_WIN_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif
  int checks = 0, errors = 0;
  inst_window_fetch dut (
    .clk(clk), .resetN(resetN), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .bank_addr(bank_addr), .bank_q(bank_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_window(rsp_window)
`ifdef INST_WIN_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  always @(posedge clk)
    for (int k = 0; k < B; k++)
      bank_q[k*IW +: IW] <= {6'b101000, bank_addr[k*RW +: RW], 5'(k)};
  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   l0, l10, l19;
    logic [4:0]    r0, r31;
  } vec_t;
  vec_t v[5];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [W*IW-1:0] win_of(input logic [AW-1:0] a);
    logic [W*IW-1:0] r;
    for (int i = 0; i < W; i++) r[i*IW +: IW] = {6'b101000, 10'(a + 10'(i))};
    return r;
  endfunction
  function automatic logic [15:0] lane(input int i);
    return rsp_window[i*IW +: IW];
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t t);
    req_valid = 1;
    req_addr  = t.addr;
    @(negedge clk);
    chk("fire_ready", 32'(req_ready), 1);
    chk("bank0_row", 32'(bank_addr[0 +: RW]), 32'(t.r0));
    chk("bank31_row", 32'(bank_addr[31*RW +: RW]), 32'(t.r31));
    step();
    req_valid = 0;
    @(negedge clk);
    chk("t1_no_valid", 32'(rsp_valid), 0);
    step();
    @(negedge clk);
    chk("t2_valid", 32'(rsp_valid), 1);
    chk("rsp_addr", 32'(rsp_addr), 32'(t.addr));
    chk("lane0", 32'(lane(0)), 32'(t.l0));
    chk("lane10", 32'(lane(10)), 32'(t.l10));
    chk("lane19", 32'(lane(19)), 32'(t.l19));
    chk("window", 32'(rsp_window === win_of(t.addr)), 1);
    step();
  endtask
  logic [AW-1:0] bp_addr[5] = '{10'h000, 10'h014, 10'h028, 10'h03C, 10'h050};
  logic          bp_ready[9] = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
  initial begin
    int idx, rc;
    logic fired;
    v[0] = '{10'h000, 16'hA000, 16'hA00A, 16'hA013, 5'd0,  5'd0};
    v[1] = '{10'h01E, 16'hA01E, 16'hA028, 16'hA031, 5'd1,  5'd0};
    v[2] = '{10'h3F5, 16'hA3F5, 16'hA3FF, 16'hA008, 5'd0,  5'd31};
    v[3] = '{10'h3FF, 16'hA3FF, 16'hA009, 16'hA012, 5'd0,  5'd31};
    v[4] = '{10'h123, 16'hA123, 16'hA12D, 16'hA136, 5'd10, 5'd9};
    resetN = 0; req_valid = 0; req_addr = '0; flush = 0; rsp_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_addr", 32'(rsp_addr), 0);
    chk("rst_rsp_window", 32'(rsp_window === '0), 1);
    step();
    resetN = 1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    step();
    for (int n = 0; n < 5; n++) run_vec(v[n]);
    // backpressure: responses held for the first 6 cycles
    idx = 0; rc = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = idx < 5;
      req_addr  = idx < 5 ? bp_addr[idx] : '0;
      rsp_ready = c >= 6;
      @(negedge clk);
      if (c < 9) chk($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'(bp_ready[c]));
      if (rsp_valid && rsp_ready) begin
        if (rc < 5) begin
          chk("bp_order", 32'(rsp_addr), 32'(bp_addr[rc]));
          chk("bp_window", 32'(rsp_window === win_of(bp_addr[rc])), 1);
        end
        rc++;
      end
      fired = req_valid && req_ready;
      step();
      if (fired) idx++;
    end
    req_valid = 0;
    chk("bp_rsp_count", 32'(rc), 5);
`ifdef INST_WIN_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 4);
`endif
    // flush: the 0x100 response must be dropped, 0x200 kept
    rsp_ready = 1;
    req_valid = 1; req_addr = 10'h100;
    step();
    flush = 1; req_addr = 10'h200;
    @(negedge clk);
    chk("flush_ready", 32'(req_ready), 1);
    step();
    flush = 0; req_valid = 0;
    @(negedge clk);
    chk("flush_no_stale", 32'(rsp_valid), 0);
    step();
    @(negedge clk);
    chk("flush_valid", 32'(rsp_valid), 1);
    chk("flush_addr", 32'(rsp_addr), 32'h200);
    chk("flush_window", 32'(rsp_window === win_of(10'h200)), 1);
    step();
    @(negedge clk);
    chk("flush_drained", 32'(rsp_valid), 0);
    step();
    // reset with a full buffer
    rsp_ready = 0;
    req_valid = 1; req_addr = 10'h000;
    step();
    req_addr = 10'h014;
    step();
    req_valid = 0;
    step();
    @(negedge clk);
    chk("pre_rst_full", 32'(req_ready), 0);
    step();
    resetN = 0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_window", 32'(rsp_window === '0), 1);
    step();
    resetN = 1;
    rsp_ready = 1;
    run_vec('{10'h040, 16'hA040, 16'hA04A, 16'hA053, 5'd2, 5'd2});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
